// File: rtl/scaler_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// scaler_cfg_ctrl
//
// Preset controller for the scaler core, clocked in the scaler output clock
// domain. Board buttons are synchronised and debounced; a rising debounced
// button requests its preset. A request is held pending until the next rising
// edge of vsyn (a frame boundary). The preset is then validated, and all eight
// configuration outputs are loaded in a single cycle.
//
// Optional feature (compile-time macro SCALER_CFG_VS_TIMEOUT_EN):
//   When defined, a pending request is forced into APPLY after TMO_CYCLES
//   cycles without a frame boundary. This lets the configuration recover when
//   no video is present. When undefined, a request waits for vsyn
//   indefinitely.
// -----------------------------------------------------------------------------
module scaler_cfg_ctrl #(
    parameter int IN_W        = 11,
    parameter int OUT_W       = 12,
    parameter int NUM_PRESETS = 4,
    parameter int DB_CYCLES   = 500000,
    parameter int DB_W        = 19,
    // Preset i occupies bits [i*W +: W]; the literals list p3 first, p0 last.
    parameter logic [NUM_PRESETS*IN_W-1:0]  P_XBGN = {11'd0,    11'd0,    11'd0,    11'd0},
    parameter logic [NUM_PRESETS*IN_W-1:0]  P_XEND = {11'd1023, 11'd511,  11'd767,  11'd1023},
    parameter logic [NUM_PRESETS*IN_W-1:0]  P_YBGN = {11'd0,    11'd0,    11'd0,    11'd0},
    parameter logic [NUM_PRESETS*IN_W-1:0]  P_YEND = {11'd767,  11'd767,  11'd767,  11'd767},
    parameter logic [NUM_PRESETS*OUT_W-1:0] P_OUTX = {12'd512,  12'd1024, 12'd1024, 12'd1024},
    parameter logic [NUM_PRESETS*OUT_W-1:0] P_OUTY = {12'd384,  12'd768,  12'd768,  12'd768},
    parameter int TMO_CYCLES  = 4000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PRESETS-1:0] btn,
    input  logic                   vsyn,
    output logic [IN_W-1:0]        xBgn,
    output logic [IN_W-1:0]        xEnd,
    output logic [IN_W-1:0]        yBgn,
    output logic [IN_W-1:0]        yEnd,
    output logic [IN_W-1:0]        inXRes,
    output logic [IN_W-1:0]        inYRes,
    output logic [OUT_W-1:0]       outXRes,
    output logic [OUT_W-1:0]       outYRes,
    output logic [((NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1)-1:0] cfgIdx,
    output logic                   cfgPending,
    output logic                   cfgUpdate,
    output logic                   cfgErr
);

    localparam int IDX_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_APPLY
    } state_t;

    // Resolution spanned by an inclusive [b, e] edge pair. The subtraction is
    // done one bit wider so a full-range window does not wrap before the +1.
    function automatic logic [IN_W-1:0] span(input logic [IN_W-1:0] b,
                                             input logic [IN_W-1:0] e);
        logic [IN_W:0] d;
        d = {1'b0, e} - {1'b0, b} + {{IN_W{1'b0}}, 1'b1};
        return d[IN_W-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Button synchronisation and debounce
    // ------------------------------------------------------------------------
    logic [NUM_PRESETS-1:0] sync1_q;
    logic [NUM_PRESETS-1:0] sync2_q;
    logic [NUM_PRESETS-1:0] db_state_q;
    logic [NUM_PRESETS-1:0] req_q;
    logic [DB_W-1:0]        db_cnt_q [NUM_PRESETS];

    // Two-flop synchroniser, stability counter per button, and rising-edge request pulse.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge value of its source, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_state_q <= '0;
            req_q      <= '0;
            // NOTE: this array holds control counters, not data storage, so it
            // is cleared on reset like any other state register.
            for (int i = 0; i < NUM_PRESETS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            req_q   <= '0;
            for (int i = 0; i < NUM_PRESETS; i++) begin
                if (sync2_q[i] == db_state_q[i]) begin
                    // Agreement with the debounced state restarts the count.
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_cnt_q[i]   <= '0;
                    db_state_q[i] <= sync2_q[i];
                    req_q[i]      <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request arbitration: the lowest index wins, the others are dropped
    // ------------------------------------------------------------------------
    logic             req_any;
    logic [IDX_W-1:0] req_pick;

    // Scan from the top so the lowest asserted index is the last one written.
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a variable unassigned and infer a latch.
    always_comb begin
        req_any  = 1'b0;
        req_pick = '0;
        for (int i = NUM_PRESETS - 1; i >= 0; i--) begin
            if (req_q[i]) begin
                req_any  = 1'b1;
                req_pick = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame boundary detection
    // ------------------------------------------------------------------------
    logic vsyn_q;
    logic vs_rise;

    // One register on vsyn to find its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsyn_q <= 1'b0;
        end else begin
            vsyn_q <= vsyn;
        end
    end

    assign vs_rise = vsyn & ~vsyn_q;

    // ------------------------------------------------------------------------
    // Preset lookup and validation for the latched request
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] req_idx_q;
    logic [IN_W-1:0]  sel_xbgn;
    logic [IN_W-1:0]  sel_xend;
    logic [IN_W-1:0]  sel_ybgn;
    logic [IN_W-1:0]  sel_yend;
    logic [OUT_W-1:0] sel_outx;
    logic [OUT_W-1:0] sel_outy;
    logic [IN_W-1:0]  inx_d;
    logic [IN_W-1:0]  iny_d;
    logic             sel_valid;

    // Mux the requested preset out of the packed tables and check it is usable.
    always_comb begin
        sel_xbgn = P_XBGN[IN_W-1:0];
        sel_xend = P_XEND[IN_W-1:0];
        sel_ybgn = P_YBGN[IN_W-1:0];
        sel_yend = P_YEND[IN_W-1:0];
        sel_outx = P_OUTX[OUT_W-1:0];
        sel_outy = P_OUTY[OUT_W-1:0];
        for (int i = 0; i < NUM_PRESETS; i++) begin
            if (req_idx_q == IDX_W'(i)) begin
                sel_xbgn = P_XBGN[i*IN_W +: IN_W];
                sel_xend = P_XEND[i*IN_W +: IN_W];
                sel_ybgn = P_YBGN[i*IN_W +: IN_W];
                sel_yend = P_YEND[i*IN_W +: IN_W];
                sel_outx = P_OUTX[i*OUT_W +: OUT_W];
                sel_outy = P_OUTY[i*OUT_W +: OUT_W];
            end
        end
        inx_d     = span(sel_xbgn, sel_xend);
        iny_d     = span(sel_ybgn, sel_yend);
        sel_valid = (sel_xend >= sel_xbgn) && (sel_yend >= sel_ybgn) &&
                    (sel_outx != '0) && (sel_outy != '0);
    end

    // ------------------------------------------------------------------------
    // Optional frame-boundary timeout
    // ------------------------------------------------------------------------
    state_t state_q;
    logic   tmo_hit;

`ifdef SCALER_CFG_VS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Count cycles spent waiting in PEND; entry to PEND and each new request restart it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if ((state_q != ST_PEND) || req_any) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (state_q == ST_PEND) && (tmo_cnt_q == TMO_LAST);
`else
    // No timeout in this build: a pending request waits for vsyn. The compare
    // below is constant false and only keeps TMO_CYCLES referenced.
    assign tmo_hit = (TMO_CYCLES < 0);
`endif

    // ------------------------------------------------------------------------
    // Control FSM with registered configuration outputs
    // ------------------------------------------------------------------------
    logic [IN_W-1:0]  xbgn_q;
    logic [IN_W-1:0]  xend_q;
    logic [IN_W-1:0]  ybgn_q;
    logic [IN_W-1:0]  yend_q;
    logic [IN_W-1:0]  inx_q;
    logic [IN_W-1:0]  iny_q;
    logic [OUT_W-1:0] outx_q;
    logic [OUT_W-1:0] outy_q;
    logic [IDX_W-1:0] cfg_idx_q;
    logic             cfg_pending_q;
    logic             cfg_update_q;
    logic             cfg_err_q;

    // IDLE -> PEND on request, PEND -> APPLY on frame boundary, APPLY commits or rejects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_idx_q     <= '0;
            xbgn_q        <= P_XBGN[IN_W-1:0];
            xend_q        <= P_XEND[IN_W-1:0];
            ybgn_q        <= P_YBGN[IN_W-1:0];
            yend_q        <= P_YEND[IN_W-1:0];
            inx_q         <= span(P_XBGN[IN_W-1:0], P_XEND[IN_W-1:0]);
            iny_q         <= span(P_YBGN[IN_W-1:0], P_YEND[IN_W-1:0]);
            outx_q        <= P_OUTX[OUT_W-1:0];
            outy_q        <= P_OUTY[OUT_W-1:0];
            cfg_idx_q     <= '0;
            cfg_pending_q <= 1'b0;
            cfg_update_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        req_idx_q     <= req_pick;
                        cfg_pending_q <= 1'b1;
                        state_q       <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // A fresh request beats a coincident frame boundary; it
                    // then waits for the following boundary.
                    if (req_any) begin
                        req_idx_q <= req_pick;
                    end else if (vs_rise || tmo_hit) begin
                        cfg_pending_q <= 1'b0;
                        state_q       <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (sel_valid) begin
                        xbgn_q       <= sel_xbgn;
                        xend_q       <= sel_xend;
                        ybgn_q       <= sel_ybgn;
                        yend_q       <= sel_yend;
                        inx_q        <= inx_d;
                        iny_q        <= iny_d;
                        outx_q       <= sel_outx;
                        outy_q       <= sel_outy;
                        cfg_idx_q    <= req_idx_q;
                        cfg_update_q <= 1'b1;
                    end else begin
                        cfg_err_q <= 1'b1;
                    end
                    if (req_any) begin
                        req_idx_q     <= req_pick;
                        cfg_pending_q <= 1'b1;
                        state_q       <= ST_PEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    cfg_pending_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign xBgn       = xbgn_q;
    assign xEnd       = xend_q;
    assign yBgn       = ybgn_q;
    assign yEnd       = yend_q;
    assign inXRes     = inx_q;
    assign inYRes     = iny_q;
    assign outXRes    = outx_q;
    assign outYRes    = outy_q;
    assign cfgIdx     = cfg_idx_q;
    assign cfgPending = cfg_pending_q;
    assign cfgUpdate  = cfg_update_q;
    assign cfgErr     = cfg_err_q;

endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scaler_cfg_ctrl
//
// Bench for scaler_cfg_ctrl with DB_CYCLES=4 and a fifth, deliberately
// invalid preset (xEnd < xBgn). Each frame-boundary stimulus pushes the
// configuration the controller should present next. A monitor pops it on
// cfgUpdate/cfgErr and checks every output. Between pulses, the monitor checks
// that the outputs hold steady.
// -----------------------------------------------------------------------------
module tb_scaler_cfg_ctrl;

    localparam int IN_W  = 11;
    localparam int OUT_W = 12;
    localparam int NP    = 5;
    localparam int IDX_W = 3;
    localparam int TMO   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     btn;
    logic              vsyn;
    logic [IN_W-1:0]   xBgn, xEnd, yBgn, yEnd, inXRes, inYRes;
    logic [OUT_W-1:0]  outXRes, outYRes;
    logic [IDX_W-1:0]  cfgIdx;
    logic              cfgPending, cfgUpdate, cfgErr;

    typedef struct packed {
        logic             is_err;
        logic [IN_W-1:0]  xb;
        logic [IN_W-1:0]  xe;
        logic [IN_W-1:0]  yb;
        logic [IN_W-1:0]  ye;
        logic [IN_W-1:0]  inx;
        logic [IN_W-1:0]  iny;
        logic [OUT_W-1:0] ox;
        logic [OUT_W-1:0] oy;
        logic [IDX_W-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t mon_e;
    exp_t mon_o;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_upd   = 0;
    int   n_err   = 0;
    int   base_u;
    int   base_e;
    int   t0;
    int   t1;
    logic seen_pend;

    scaler_cfg_ctrl #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .NUM_PRESETS (NP),
        .DB_CYCLES   (4),
        .DB_W        (3),
        .P_XBGN      ({11'd100, 11'd0,    11'd0,   11'd0,   11'd0}),
        .P_XEND      ({11'd50,  11'd1023, 11'd511, 11'd767, 11'd1023}),
        .P_YBGN      ({11'd0,   11'd0,    11'd0,   11'd0,   11'd0}),
        .P_YEND      ({11'd767, 11'd767,  11'd767, 11'd767, 11'd767}),
        .P_OUTX      ({12'd1024, 12'd512, 12'd1024, 12'd1024, 12'd1024}),
        .P_OUTY      ({12'd768,  12'd384, 12'd768,  12'd768,  12'd768}),
        .TMO_CYCLES  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .vsyn       (vsyn),
        .xBgn       (xBgn),
        .xEnd       (xEnd),
        .yBgn       (yBgn),
        .yEnd       (yEnd),
        .inXRes     (inXRes),
        .inYRes     (inYRes),
        .outXRes    (outXRes),
        .outYRes    (outYRes),
        .cfgIdx     (cfgIdx),
        .cfgPending (cfgPending),
        .cfgUpdate  (cfgUpdate),
        .cfgErr     (cfgErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected active configuration per preset, written out as plain numbers.
    function automatic exp_t exp_cfg(input int idx, input logic is_err);
        exp_t e;
        e.is_err = is_err;
        e.xb     = 11'd0;
        e.yb     = 11'd0;
        e.ye     = 11'd767;
        e.iny    = 11'd768;
        e.ox     = 12'd1024;
        e.oy     = 12'd768;
        e.idx    = IDX_W'(idx);
        case (idx)
            1:       begin e.xe = 11'd767;  e.inx = 11'd768;  end
            2:       begin e.xe = 11'd511;  e.inx = 11'd512;  end
            3:       begin e.xe = 11'd1023; e.inx = 11'd1024; e.ox = 12'd512; e.oy = 12'd384; end
            default: begin e.xe = 11'd1023; e.inx = 11'd1024; end
        endcase
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.is_err = 1'b0;
        o.xb  = xBgn;    o.xe  = xEnd;   o.yb = yBgn;    o.ye = yEnd;
        o.inx = inXRes;  o.iny = inYRes; o.ox = outXRes; o.oy = outYRes;
        o.idx = cfgIdx;
        return o;
    endfunction

    // Scoreboard monitor: pop and compare on each pulse, otherwise outputs must hold.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            cur = exp_cfg(0, 1'b0);
            exp_q.delete();
        end else if (cfgUpdate || cfgErr) begin
            if (cfgUpdate) n_upd++;
            if (cfgErr)    n_err++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {cfgUpdate, cfgErr}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                mon_o = obs();
                check("pulse_kind", {cfgUpdate, cfgErr}, mon_e.is_err ? 2'b01 : 2'b10);
                check("xBgn",    mon_o.xb,  mon_e.xb);
                check("xEnd",    mon_o.xe,  mon_e.xe);
                check("yBgn",    mon_o.yb,  mon_e.yb);
                check("yEnd",    mon_o.ye,  mon_e.ye);
                check("inXRes",  mon_o.inx, mon_e.inx);
                check("inYRes",  mon_o.iny, mon_e.iny);
                check("outXRes", mon_o.ox,  mon_e.ox);
                check("outYRes", mon_o.oy,  mon_e.oy);
                check("cfgIdx",  mon_o.idx, mon_e.idx);
                cur        = mon_e;
                cur.is_err = 1'b0;
            end
        end else begin
            check("hold_steady", obs(), cur);
        end
    end

    task automatic press(input logic [NP-1:0] mask, input int hold);
        btn = mask;
        repeat (hold) @(negedge clk);
        btn = '0;
    endtask

    task automatic vs_pulse();
        vsyn = 1'b1;
        repeat (2) @(negedge clk);
        vsyn = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        btn  = '0;
        vsyn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state: preset 0, no pulses.
        check("rst_xBgn",    xBgn,    11'd0);
        check("rst_xEnd",    xEnd,    11'd1023);
        check("rst_yBgn",    yBgn,    11'd0);
        check("rst_yEnd",    yEnd,    11'd767);
        check("rst_inXRes",  inXRes,  11'd1024);
        check("rst_inYRes",  inYRes,  11'd768);
        check("rst_outXRes", outXRes, 12'd1024);
        check("rst_outYRes", outYRes, 12'd768);
        check("rst_cfgIdx",  cfgIdx,  3'd0);
        check("rst_flags",   {cfgPending, cfgUpdate, cfgErr}, 3'b000);

        // Preset 2 held pending until the frame boundary.
        base_u = n_upd;
        press(5'b00100, 10);
        check("s2_pending",   cfgPending, 1'b1);
        check("s2_xEnd_hold", xEnd, 11'd1023);
        check("s2_idx_hold",  cfgIdx, 3'd0);
        exp_q.push_back(exp_cfg(2, 1'b0));
        vs_pulse();
        wait_drain(20);
        settle(10);
        check("s2_upd_cnt",  n_upd - base_u, 1);
        check("s2_pend_clr", cfgPending, 1'b0);

        // Bouncing button never settles long enough to request.
        base_u    = n_upd;
        seen_pend = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn[1] = (i < 2) || (i >= 4 && i < 6);
            @(negedge clk);
            if (cfgPending) seen_pend = 1'b1;
        end
        check("s3_no_pend", seen_pend, 1'b0);
        check("s3_no_upd",  n_upd - base_u, 0);

        // Last request before the boundary wins.
        base_u = n_upd;
        press(5'b00010, 8);
        press(5'b01000, 8);
        check("s4_pending",  cfgPending, 1'b1);
        check("s4_idx_hold", cfgIdx, 3'd2);
        exp_q.push_back(exp_cfg(3, 1'b0));
        vs_pulse();
        wait_drain(20);
        settle(10);
        check("s4_upd_cnt", n_upd - base_u, 1);

        // Simultaneous presses: lowest index wins.
        base_u = n_upd;
        press(5'b00110, 8);
        exp_q.push_back(exp_cfg(1, 1'b0));
        vs_pulse();
        wait_drain(20);
        settle(10);
        check("s5_upd_cnt", n_upd - base_u, 1);
        check("s5_xEnd",    xEnd, 11'd767);

        // Invalid preset: one cfgErr, outputs unchanged.
        base_u = n_upd;
        base_e = n_err;
        press(5'b10000, 8);
        exp_q.push_back(exp_cfg(1, 1'b1));
        vs_pulse();
        wait_drain(20);
        settle(10);
        check("s6_err_cnt", n_err - base_e, 1);
        check("s6_upd_cnt", n_upd - base_u, 0);
        check("s6_idx",     cfgIdx, 3'd1);

        // Reselecting the active preset still commits.
        base_u = n_upd;
        press(5'b00010, 8);
        exp_q.push_back(exp_cfg(1, 1'b0));
        vs_pulse();
        wait_drain(20);
        settle(10);
        check("s7_upd_cnt", n_upd - base_u, 1);

`ifdef SCALER_CFG_VS_TIMEOUT_EN
        // No video: the timeout forces the commit.
        exp_q.push_back(exp_cfg(3, 1'b0));
        t0  = -1;
        t1  = -1;
        btn = 5'b01000;
        for (int i = 0; i < 60 && t1 < 0; i++) begin
            @(negedge clk);
            if (i == 9) btn = '0;
            if (cfgPending && t0 < 0) t0 = i;
            if (cfgUpdate) t1 = i;
        end
        check("s8_tmo_delay", t1 - t0, TMO + 1);
        wait_drain(5);
        settle(10);
`else
        // No video: the request waits indefinitely.
        base_u = n_upd;
        press(5'b01000, 10);
        settle(40);
        check("s8_still_pend", cfgPending, 1'b1);
        check("s8_no_upd",     n_upd - base_u, 0);
        exp_q.push_back(exp_cfg(3, 1'b0));
        vs_pulse();
        wait_drain(20);
        settle(10);
        check("s8_upd_cnt", n_upd - base_u, 1);
`endif

        // Reset mid-PEND drops the request.
        press(5'b00100, 10);
        check("s9_pending", cfgPending, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("s9_rst_pend",   cfgPending, 1'b0);
        check("s9_rst_xEnd",   xEnd, 11'd1023);
        check("s9_rst_idx",    cfgIdx, 3'd0);
        check("s9_rst_inXRes", inXRes, 11'd1024);
        rst = 1'b0;
        @(negedge clk);
        base_u = n_upd;
        vs_pulse();
        settle(10);
        check("s9_no_upd",  n_upd - base_u, 0);
        check("s9_no_pend", cfgPending, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/scaler_cfg_ctrl.md
Name: scaler_cfg_ctrl

Overview:
Synchronous preset controller that drives the crop window and resolution inputs of the scaler core. It replaces button-clocked configuration logic with synchronised, debounced button inputs and a parametrised preset table. Configuration changes are applied atomically, only on a frame boundary. It sits between the board buttons and the scaler core and runs in the output clock domain.

Parameters:
IN_W, 11, width of crop-edge and input-resolution outputs
OUT_W, 12, width of output-resolution outputs
NUM_PRESETS, 4, number of presets; button i selects preset i; preset 0 is the reset default
DB_CYCLES, 500000, number of consecutive stable cycles before a debounced button changes state
DB_W, 19, debounce counter width; must hold DB_CYCLES
P_XBGN, P_XEND, P_YBGN, P_YEND, packed NUM_PRESETS*IN_W each, crop edges; preset i in bits [i*IN_W +: IN_W]
P_OUTX, P_OUTY, packed NUM_PRESETS*OUT_W each, output resolution per preset
Default table:
- p0: x 0..1023, y 0..767, out 1024x768
- p1: x 0..767, y 0..767, out 1024x768
- p2: x 0..511, y 0..767, out 1024x768
- p3: x 0..1023, y 0..767, out 512x384
TMO_CYCLES, 4000000, VS-timeout limit; used only with the optional feature

Ports:
clk  input  1  controller clock (scaler clkb domain)
rst  input  1  reset; asynchronous, active-high
btn  input  NUM_PRESETS  raw asynchronous buttons, active-high
vsyn  input  1  output field sync, synchronous to clk; a rising edge marks a frame boundary
xBgn, xEnd, yBgn, yEnd  output  IN_W  active crop edges
inXRes, inYRes  output  IN_W  active input resolution, derived from the crop edges
outXRes, outYRes  output  OUT_W  active output resolution
cfgIdx  output  log2(NUM_PRESETS) (min 1)  index of the active preset
cfgPending  output  1  high while a request is waiting for a frame boundary
cfgUpdate  output  1  one-cycle pulse in the cycle the active outputs change
cfgErr  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (async assert, synchronous release):
  - All outputs take the preset-0 values; inXRes=1024, inYRes=768.
  - cfgIdx=0; cfgPending, cfgUpdate and cfgErr are 0.
  - FSM goes to IDLE; debounce counters and synchronisers clear.
- Each btn bit:
  - Passes through a 2-FF synchroniser.
  - Debounced state flips only after the synchronised value differs from it for DB_CYCLES consecutive cycles; any bounce restarts the counter at 0.
  - A 0->1 transition of the debounced state is a one-cycle request pulse.
- Simultaneous request pulses: the lowest index wins; the others are dropped.
- vsyn is registered once; vsRise = vsyn & ~vsyn_q.
- FSM:
  - IDLE: on request, latch reqIdx and go to PEND.
  - PEND: cfgPending=1.
    - A new request overwrites reqIdx and stays in PEND (last request wins).
    - On vsRise, go to APPLY.
    - If vsRise and a new request arrive in the same cycle, the new request is latched and applies at the next frame boundary.
  - APPLY (1 cycle):
    - Validate the preset: xEnd>=xBgn, yEnd>=yBgn, outXRes!=0 and outYRes!=0.
    - Valid: load all outputs on the next edge and pulse cfgUpdate together with the new values. inXRes = xEnd-xBgn+1 and inYRes = yEnd-yBgn+1, computed at IN_W+1 bits and truncated to IN_W.
    - Invalid: outputs unchanged; pulse cfgErr.
    - Return to IDLE, or to PEND if a request arrived during APPLY.
- Output updates:
  - Outputs change only in the cycle after APPLY, so all eight values change in the same cycle.
  - Selecting the already-active preset still completes a full commit with a cfgUpdate pulse.
- Reset mid-PEND drops the pending request.
- Latency, button press to outputs: 2 sync + DB_CYCLES + 1 edge, plus the wait for vsRise, plus 2.

Optional Feature:
Macro SCALER_CFG_VS_TIMEOUT_EN.
- Defined: a DB_W-independent counter counts cycles spent in PEND.
  - If it reaches TMO_CYCLES without a vsRise, the FSM enters APPLY anyway.
  - The counter clears on entry to PEND and on every request.
  - This lets the configuration recover when no video is present.
- Not defined: no counter; PEND waits indefinitely for vsRise.

Test Plan:
All scenarios use DB_CYCLES=4.
1. Reset -> xEnd=1023, yEnd=767, inXRes=1024, outXRes=1024, outYRes=768, cfgIdx=0, no pulses.
2. Hold btn[2] high for 10 cycles, then raise vsyn -> cfgPending=1 until vsRise; then xEnd=511, inXRes=512, cfgIdx=2, one cfgUpdate pulse; xEnd stays unchanged before vsRise.
3. btn[1] bounces 1-0-1-0 at 2-cycle intervals, then stays low -> no request, cfgPending stays 0.
4. Press btn[1], then btn[3] before vsRise -> after the commit outXRes=512, outYRes=384, inXRes=1024, cfgIdx=3.
5. Press btn[1] and btn[2] simultaneously, then vsRise -> cfgIdx=1, xEnd=767.
6. Preset with xEnd<xBgn, press and vsRise -> cfgErr pulses once, outputs unchanged. With SCALER_CFG_VS_TIMEOUT_EN, TMO_CYCLES=16 and vsyn held low -> commit occurs 16 cycles after entering PEND.
